// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction memory port arbiter
package imem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {ARB, LOCK} arb_state_t;

    typedef struct packed {
        logic v;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// rtl/rd_return_pipe.sv - fixed-latency shift of read tags so returning data can be routed to its issuer
module rd_return_pipe
    import imem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    clear,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    busy
);

    rd_tag_t stage [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LATENCY-1];

    // Any valid tag anywhere in the pipe means a read is still outstanding.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy = busy | stage[i].v;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - round-robin arbiter sharing one memory port between CPU fetch and program loader
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    input  logic                      lock_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              rr_last;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;
    logic              in_flight;
    logic              unused_addr_bits;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ARB;
            rr_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (|gnt_o) begin
                rr_last <= sel;
            end
        end
    end

    // While lock_i is up (draining or locked) port 0 is never granted, so no
    // fetch read can slip into the pipe ahead of the loader's exclusive window.
    always_comb begin
        gnt_o     = '0;
        state_nxt = state;
        case (state)
            ARB: begin
                if (lock_i) begin
                    gnt_o = {req_i[1], 1'b0};
                    if (!in_flight) begin
                        state_nxt = LOCK;
                    end
                end else if (req_i == 2'b11) begin
                    gnt_o = rr_last ? 2'b01 : 2'b10;
                end else begin
                    gnt_o = req_i;
                end
            end
            LOCK: begin
                gnt_o = {req_i[1], 1'b0};
                if (!lock_i) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!reset) begin
            gnt_o = '0;
        end
    end

    assign sel      = gnt_o[1];
    assign sel_addr = sel ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];

    always_comb begin
        mem_en    = |gnt_o;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            mem_we    = we_i[sel];
            mem_addr  = {2'b00, sel_addr[ADDR_W-1:2]};
            mem_wdata = sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
        end
    end

    // Byte offset is dropped: memory is word addressed.
    assign unused_addr_bits = ^sel_addr[1:0];

    always_comb begin
        tag_in       = '0;
        tag_in.v     = mem_en & ~mem_we;
        tag_in.owner = sel;
    end

    rd_return_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_return_pipe (
        .clk    (clk),
        .clear  (~reset),
        .tag_in (tag_in),
        .tag_out(tag_out),
        .busy   (in_flight)
    );

    assign rvalid_o = (reset && tag_out.v) ? (tag_out.owner ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = (|rvalid_o) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter at read latencies 1 and 3
module tb_imem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    req       [2];
    logic [1:0]    we        [2];
    logic [2*AW-1:0] addr    [2];
    logic [2*DW-1:0] wdata   [2];
    logic          lock      [2];
    logic [1:0]    gnt       [2];
    logic [1:0]    rvalid    [2];
    logic [DW-1:0] rdata     [2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .lock_i(lock[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .lock_i(lock[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: reads are booked by the cycle they are due back; port 0 is
    // shut out whenever the loader holds or asks for the lock.
    int         cyc = 0;
    int         due_v [2][16];
    bit         m_lock [2];
    bit         m_last [2];
    logic [1:0] exp_gnt [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int            lat, s, g;
            bit            infl, een, ewe;
            logic [1:0]    want, eg, erv;
            logic [AW-1:0] ea, full_a;
            logic [DW-1:0] ewd, erd;
            lat  = (d == 0) ? 1 : 3;
            s    = cyc % 16;
            infl = 1'b0;
            for (int k = 0; k < lat; k++) begin
                if (due_v[d][(cyc + k) % 16] != 0) infl = 1'b1;
            end
            eg = 2'b00;
            if (reset) begin
                want = req[d];
                if (m_lock[d] || lock[d]) want[0] = 1'b0;
                eg = (want == 2'b11) ? (m_last[d] ? 2'b01 : 2'b10) : want;
            end
            g      = eg[1] ? 1 : 0;
            een    = (eg != 2'b00);
            ewe    = een && we[d][g];
            full_a = addr[d][g*AW +: AW];
            ea     = een ? (full_a >> 2) : '0;
            ewd    = een ? wdata[d][g*DW +: DW] : '0;
            erv    = (reset && due_v[d][s] != 0) ? ((due_v[d][s] == 2) ? 2'b10 : 2'b01) : 2'b00;
            erd    = (erv != 2'b00) ? mem_rdata[d] : '0;
            chk($sformatf("c%0d d%0d gnt", cyc, d), gnt[d], eg);
            chk($sformatf("c%0d d%0d mem_en", cyc, d), mem_en[d], een);
            chk($sformatf("c%0d d%0d mem_we", cyc, d), mem_we[d], ewe);
            chk($sformatf("c%0d d%0d mem_addr", cyc, d), mem_addr[d], ea);
            chk($sformatf("c%0d d%0d mem_wdata", cyc, d), mem_wdata[d], ewd);
            chk($sformatf("c%0d d%0d rvalid", cyc, d), rvalid[d], erv);
            chk($sformatf("c%0d d%0d rdata", cyc, d), rdata[d], erd);
            exp_gnt[d]   = eg;
            due_v[d][s]  = 0;
            if (!reset) begin
                for (int k = 0; k < 16; k++) due_v[d][k] = 0;
                m_lock[d] = 1'b0;
                m_last[d] = 1'b0;
            end else begin
                if (een) begin
                    m_last[d] = eg[1];
                    if (!ewe) due_v[d][(cyc + lat) % 16] = g + 1;
                end
                if (m_lock[d] && !lock[d]) m_lock[d] = 1'b0;
                else if (!m_lock[d] && lock[d] && !infl) m_lock[d] = 1'b1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b00; we[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
            lock[d] = 1'b0; mem_rdata[d] = '0; exp_gnt[d] = 2'b00;
            m_lock[d] = 1'b0; m_last[d] = 1'b0;
            for (int k = 0; k < 16; k++) due_v[d][k] = 0;
        end

        // reset held with both ports requesting
        req[0] = 2'b11; req[1] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            chk("rst_gnt", gnt[0], 2'b00);
            chk("rst_mem_en", mem_en[0], 1'b0);
            chk("rst_rvalid0", rvalid[0], 2'b00);
            chk("rst_rvalid1", rvalid[1], 2'b00);
        end

        // single port-0 read at 0x100
        tick();
        reset = 1'b1; req[0] = 2'b01; req[1] = 2'b00; we[0] = 2'b00;
        addr[0] = {32'h0, 32'h100};
        #3;
        chk("rd0_gnt", gnt[0], 2'b01);
        chk("rd0_addr", mem_addr[0], 32'h40);
        tick();
        req[0] = 2'b00; mem_rdata[0] = 32'hCAFE0001;
        #3;
        chk("rd0_rvalid", rvalid[0], 2'b01);
        chk("rd0_rdata", rdata[0], 32'hCAFE0001);

        // round robin with both ports requesting
        tick(); reset = 1'b0;
        tick(); reset = 1'b1; req[0] = 2'b11; addr[0] = {32'h8, 32'h4};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i == 4) req[0] = 2'b00;
            #3;
            if (i < 4) chk("rr_gnt", gnt[0], (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) chk("rr_rvalid", rvalid[0], (i % 2 == 1) ? 2'b10 : 2'b01);
        end

        // lock while a port-0 read is in flight
        tick(); reset = 1'b0;
        tick(); reset = 1'b1; req[0] = 2'b01; addr[0] = {32'h0, 32'h200};
        #3; chk("lk_first_gnt", gnt[0], 2'b01);
        tick(); lock[0] = 1'b1;
        #3; chk("lk_drain_gnt", gnt[0], 2'b00); chk("lk_drain_rvalid", rvalid[0], 2'b01);
        tick();
        #3; chk("lk_enter_gnt", gnt[0], 2'b00);
        tick(); req[0] = 2'b11; we[0] = 2'b10; addr[0] = {32'h0, 32'h200};
        wdata[0] = {32'hDEADBEEF, 32'h0};
        #3;
        chk("lk_w0_gnt", gnt[0], 2'b10); chk("lk_w0_we", mem_we[0], 1'b1);
        chk("lk_w0_addr", mem_addr[0], 32'h0); chk("lk_w0_data", mem_wdata[0], 32'hDEADBEEF);
        tick(); addr[0] = {32'h4, 32'h200}; wdata[0] = {32'h1, 32'h0};
        #3;
        chk("lk_w1_gnt", gnt[0], 2'b10); chk("lk_w1_we", mem_we[0], 1'b1);
        chk("lk_w1_addr", mem_addr[0], 32'h1); chk("lk_w1_data", mem_wdata[0], 32'h1);
        tick(); req[0] = 2'b01; we[0] = 2'b00;
        #3; chk("lk_starve_gnt", gnt[0], 2'b00);
        tick(); lock[0] = 1'b0;
        #3; chk("lk_exit_gnt", gnt[0], 2'b00);
        tick();
        #3; chk("lk_release_gnt", gnt[0], 2'b01);

        // reset while a port-1 read is in flight
        tick(); reset = 1'b0; req[0] = 2'b00;
        tick(); reset = 1'b1; req[0] = 2'b10; we[0] = 2'b00;
        #3; chk("rf_gnt", gnt[0], 2'b10);
        tick(); reset = 1'b0; req[0] = 2'b00; mem_rdata[0] = 32'h5555AAAA;
        #3; chk("rf_rvalid_rst", rvalid[0], 2'b00);
        tick(); reset = 1'b1; req[0] = 2'b01;
        #3; chk("rf_first_gnt", gnt[0], 2'b01); chk("rf_rvalid_after", rvalid[0], 2'b00);
        tick(); req[0] = 2'b00;
        #3; chk("rf_p0_rvalid", rvalid[0], 2'b01);

        // latency 3, back-to-back alternating reads
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            req[1] = (i < 4) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            we[1] = 2'b00; addr[1] = {32'h40, 32'h80};
            mem_rdata[1] = 32'h1000 + i;
            #3;
            if (i < 4) chk("l3_gnt", gnt[1], (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i >= 3 && i <= 6) begin
                chk("l3_rvalid", rvalid[1], ((i - 3) % 2 == 1) ? 2'b10 : 2'b01);
                chk("l3_rdata", rdata[1], 32'h1000 + i);
            end else begin
                chk("l3_rvalid_idle", rvalid[1], 2'b00);
            end
        end

        // randomized traffic, lock toggling and occasional reset
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom_range(0, 199) != 0);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!req[d][k] || exp_gnt[d][k]) begin
                        if ($urandom_range(0, 2) != 0) begin
                            req[d][k] = 1'b1;
                            we[d][k] = ($urandom_range(0, 3) == 0);
                            addr[d][k*AW +: AW] = $urandom;
                            wdata[d][k*DW +: DW] = $urandom;
                        end else begin
                            req[d][k] = 1'b0;
                        end
                    end
                end
                if ($urandom_range(0, 15) == 0) lock[d] = ~lock[d];
                mem_rdata[d] = $urandom;
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
